// File: rtl/board_pkg.sv
// Shared constants and types for the board scanner.
// Contents: default board placement (base, word count, first address past the board),
//           the 7-bit board word index type and the scanner FSM state enum.
package board_pkg;

  localparam logic [31:0] BOARD_BASE  = 32'h0000_1000;
  localparam int unsigned BOARD_WORDS = 100;
  localparam logic [31:0] BOARD_END   = 32'h0000_1190;

  typedef logic [6:0] board_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StCapt,
    StOut
  } scan_state_e;

endpackage

// File: rtl/board_scanner_if.sv
// Bus bundle between the board scanner, the board RAM read port and the word consumer.
// master: scanner side (drives read request and output word, receives read data and ready).
// slave : RAM/consumer side (mirror image).
interface board_scanner_if;
  import board_pkg::*;

  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  board_idx_t  out_index;
  logic [31:0] out_data;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_index,
    output out_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_index,
    input  out_data
  );

endinterface

// File: rtl/board_idx_counter.sv
// Board word index counter.
// Ports: clk, rst (sync, active-high); clear -> index 0; inc -> index+1, wrapping to 0
//        after N_WORDS-1; idx = current index; last = index is N_WORDS-1.
// clear has priority over inc.
module board_idx_counter
  import board_pkg::*;
#(
  parameter int unsigned N_WORDS = BOARD_WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output board_idx_t idx,
  output logic       last
);

  localparam board_idx_t LastIdx = board_idx_t'(N_WORDS - 1);

  board_idx_t idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + board_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == LastIdx);

endmodule

// File: rtl/board_scanner.sv
// Board scanner: reads N_WORDS consecutive 32-bit words from the board RAM and hands them
// one at a time to a ready/valid consumer, one word per three cycles at full rate.
// Ports: clk, rst (sync, active-high); start (begin a frame, seen only when idle);
//        continuous (roll straight into the next frame at frame end); busy (not idle);
//        frame_done (pulse on acceptance of the last word);
//        bus (master): mem_addr/mem_rd_en/mem_rdata read port, out_valid/out_ready/
//        out_index/out_data word stream.
module board_scanner
  import board_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BOARD_BASE,
  parameter int unsigned N_WORDS   = BOARD_WORDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            continuous,
  output logic            busy,
  output logic            frame_done,
  board_scanner_if.master bus
);

  scan_state_e state_q, state_d;

  board_idx_t  idx;
  logic        idx_last;
  logic        cnt_clear;
  logic        cnt_inc;
  logic        capture;
  logic        accept;

  board_idx_t  out_index_q;
  logic [31:0] out_data_q;

  board_idx_counter #(
    .N_WORDS (N_WORDS)
  ) u_idx_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (idx_last)
  );

  assign accept = (state_q == StOut) && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        state_d = StCapt;
      end
      // Address has been stable for a full cycle here, so both combinational and
      // one-cycle registered RAMs deliver valid data by the end of this state.
      StCapt: begin
        capture = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          cnt_inc = 1'b1;
          // continuous only matters on the final-word handshake.
          state_d = (idx_last && !continuous) ? StIdle : StAddr;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        out_index_q <= idx;
        out_data_q  <= bus.mem_rdata;
      end
    end
  end

  // Index only changes on acceptance, so the address is stable through ADDR and CAPT;
  // with index 0 in idle and after reset it also rests at BASE_ADDR.
  assign bus.mem_addr  = BASE_ADDR + {23'd0, idx, 2'b00};
  assign bus.mem_rd_en = (state_q == StAddr) || (state_q == StCapt);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = accept && idx_last;

endmodule

// File: tb/tb_board_scanner.sv
module tb_board_scanner;
  import board_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic continuous;
  logic busy;
  logic frame_done;

  board_scanner_if bus ();

  board_scanner #(
    .BASE_ADDR (32'h0000_1000),
    .N_WORDS   (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int          fd_count = 0;
  int          fd_idx   = -1;
  int unsigned fd_cyc_prev = 0;
  int unsigned fd_cyc_last = 0;
  logic [31:0] max_addr = '0;
  logic        reg_mode = 1'b0;
  logic [31:0] rdata_q;

  typedef struct packed {
    logic [6:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  // Board RAM model: word i holds 0xA000_0000 + i.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a >= 32'h0000_1000 && a < 32'h0000_1190) begin
      return 32'hA000_0000 + ((a - 32'h0000_1000) >> 2);
    end
    return 32'hDEAD_BEEF;
  endfunction

  always_ff @(posedge clk) begin
    cyc     <= cyc + 1;
    rdata_q <= ram_word(bus.mem_addr);
  end

  assign bus.mem_rdata = reg_mode ? rdata_q : ram_word(bus.mem_addr);

  // Scoreboard / bus monitor, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.mem_rd_en === 1'b1) begin
          total++;
          if (bus.mem_addr < 32'h0000_1000 || bus.mem_addr >= 32'h0000_1190 ||
              bus.mem_addr[1:0] != 2'b00) begin
            bad++;
            $display("FAIL addr_range got=%h required 0x1000..0x118C word-aligned",
                     bus.mem_addr);
          end
          if (bus.mem_addr > max_addr) max_addr = bus.mem_addr;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got idx=%0d data=%h required no word",
                     bus.out_index, bus.out_data);
          end else begin
            e = sb_q.pop_front();
            if ({bus.out_index, bus.out_data} !== e) begin
              bad++;
              $display("FAIL sb_word got idx=%0d data=%h required idx=%0d data=%h",
                       bus.out_index, bus.out_data, e.idx, e.data);
            end
          end
        end
        if (frame_done === 1'b1) begin
          fd_count++;
          fd_idx      = int'(bus.out_index);
          fd_cyc_prev = fd_cyc_last;
          fd_cyc_last = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      e.idx  = 7'(i);
      e.data = 32'hA000_0000 + 32'(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    continuous = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    total++;
    if (bus.mem_addr !== 32'h0000_1000) begin
      bad++; $display("FAIL reset_mem_addr got=%h required=%h", bus.mem_addr, 32'h1000);
    end
    total++;
    if (bus.mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL reset_mem_rd_en got=%b required=0", bus.mem_rd_en);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid);
    end
    total++;
    if (bus.out_index !== 7'd0) begin
      bad++; $display("FAIL reset_out_index got=%0d required=0", bus.out_index);
    end
    total++;
    if (bus.out_data !== 32'd0) begin
      bad++; $display("FAIL reset_out_data got=%h required=0", bus.out_data);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy_start_ignored got=%b required=0", busy);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_frame_done got=%b required=0", frame_done);
    end
    rst = 1'b0;
    start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_start got busy=%b required=0", busy);
    end
  endtask

  task automatic test_single_frame();
    int unsigned c0;
    reg_mode = 1'b0;
    bus.out_ready = 1'b1;
    continuous = 1'b0;
    fd_count = 0;
    push_frame();
    pulse_start();
    c0 = cyc;
    for (int n = 0; n < 400 && busy === 1'b1; n++) step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_timeout got busy=%b required=0", busy);
    end
    total++;
    if (cyc - c0 != 300) begin
      bad++; $display("FAIL single_cycles got=%0d required=300", cyc - c0);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL single_words_left got=%0d required=0", sb_q.size());
    end
    total++;
    if (fd_count != 1 || fd_idx != 99) begin
      bad++; $display("FAIL single_frame_done got count=%0d idx=%0d required 1 at 99",
                      fd_count, fd_idx);
    end
  endtask

  task automatic test_backpressure();
    logic found;
    found = 1'b0;
    fd_count = 0;
    bus.out_ready = 1'b1;
    push_frame();
    pulse_start();
    for (int n = 0; n < 100 && !found; n++) begin
      if (bus.out_valid === 1'b1 && bus.out_index === 7'd7) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL bp_find_idx7 got none required out_index=7");
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 7'd7 ||
          bus.out_data !== 32'hA000_0007 || bus.mem_rd_en !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold got valid=%b idx=%0d data=%h rd=%b required 1/7/a0000007/0",
                 bus.out_valid, bus.out_index, bus.out_data, bus.mem_rd_en);
      end
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h0000_1020) begin
      bad++; $display("FAIL bp_next_addr got rd=%b addr=%h required 1/00001020",
                      bus.mem_rd_en, bus.mem_addr);
    end
    for (int n = 0; n < 400 && busy === 1'b1; n++) step();
    total++;
    if (busy !== 1'b0 || sb_q.size() != 0 || fd_count != 1) begin
      bad++; $display("FAIL bp_frame_end got busy=%b left=%0d fd=%0d required 0/0/1",
                      busy, sb_q.size(), fd_count);
    end
  endtask

  task automatic test_continuous();
    logic        checked;
    logic        busy_drop;
    logic [31:0] last_rd;
    checked = 1'b0;
    busy_drop = 1'b0;
    last_rd = '0;
    fd_count = 0;
    continuous = 1'b1;
    bus.out_ready = 1'b1;
    push_frame();
    push_frame();
    pulse_start();
    for (int n = 0; n < 700 && fd_count < 2; n++) begin
      step();
      if (fd_count < 2 && busy !== 1'b1) busy_drop = 1'b1;
      if (fd_count == 1 && !checked) begin
        checked = 1'b1;
        total++;
        if (bus.mem_addr !== 32'h0000_1000 || bus.mem_rd_en !== 1'b1 ||
            last_rd !== 32'h0000_118C) begin
          bad++;
          $display("FAIL cont_wrap got addr=%h rd=%b prev=%h required 00001000/1/0000118c",
                   bus.mem_addr, bus.mem_rd_en, last_rd);
        end
        continuous = 1'b0;
      end
      if (bus.mem_rd_en === 1'b1) last_rd = bus.mem_addr;
    end
    total++;
    if (fd_count != 2) begin
      bad++; $display("FAIL cont_fd_count got=%0d required=2", fd_count);
    end
    total++;
    if (fd_cyc_last - fd_cyc_prev != 300) begin
      bad++; $display("FAIL cont_fd_spacing got=%0d required=300", fd_cyc_last - fd_cyc_prev);
    end
    total++;
    if (busy_drop !== 1'b0) begin
      bad++; $display("FAIL cont_busy_held got drop=%b required=0", busy_drop);
    end
    step();
    total++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      bad++; $display("FAIL cont_end_idle got busy=%b left=%0d required 0/0",
                      busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    fd_count = 0;
    continuous = 1'b0;
    bus.out_ready = 1'b1;
    push_frame();
    pulse_start();
    for (int n = 0; n < 300 && !found; n++) begin
      if (bus.out_valid === 1'b1 && bus.out_index === 7'd50) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rstmid_find_idx50 got none required out_index=50");
    end
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    total++;
    if (bus.mem_addr !== 32'h0000_1000 || bus.mem_rd_en !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_index !== 7'd0 || bus.out_data !== 32'd0 || busy !== 1'b0 ||
        frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_outputs got addr=%h rd=%b v=%b idx=%0d data=%h busy=%b fd=%b %s",
               bus.mem_addr, bus.mem_rd_en, bus.out_valid, bus.out_index, bus.out_data,
               busy, frame_done, "required 00001000/0/0/0/0/0/0");
    end
    rst = 1'b0;
    sb_q.delete();
    step();
    total++;
    if (busy !== 1'b0 || fd_count != 0) begin
      bad++; $display("FAIL rstmid_aborted got busy=%b fd=%0d required 0/0", busy, fd_count);
    end
    push_frame();
    bus.out_ready = 1'b1;
    pulse_start();
    total++;
    if (bus.mem_addr !== 32'h0000_1000 || bus.mem_rd_en !== 1'b1) begin
      bad++; $display("FAIL rstmid_restart_addr got addr=%h rd=%b required 00001000/1",
                      bus.mem_addr, bus.mem_rd_en);
    end
    for (int n = 0; n < 400 && busy === 1'b1; n++) step();
    total++;
    if (busy !== 1'b0 || sb_q.size() != 0 || fd_count != 1 || fd_idx != 99) begin
      bad++; $display("FAIL rstmid_frame got busy=%b left=%0d fd=%0d at %0d required 0/0/1/99",
                      busy, sb_q.size(), fd_count, fd_idx);
    end
  endtask

  task automatic test_restart_regram();
    int unsigned c0;
    logic        pulsed;
    pulsed = 1'b0;
    reg_mode = 1'b1;
    fd_count = 0;
    max_addr = '0;
    continuous = 1'b0;
    bus.out_ready = 1'b1;
    push_frame();
    pulse_start();
    c0 = cyc;
    for (int n = 0; n < 400 && busy === 1'b1; n++) begin
      if (!pulsed && bus.out_valid === 1'b1 && bus.out_index === 7'd20) begin
        pulsed = 1'b1;
        start = 1'b1;
        step();
        step();
        step();
        start = 1'b0;
      end else begin
        step();
      end
    end
    total++;
    if (!pulsed || busy !== 1'b0) begin
      bad++; $display("FAIL regram_run got pulsed=%b busy=%b required 1/0", pulsed, busy);
    end
    total++;
    if (cyc - c0 != 300) begin
      bad++; $display("FAIL regram_cycles got=%0d required=300", cyc - c0);
    end
    total++;
    if (sb_q.size() != 0 || fd_count != 1) begin
      bad++; $display("FAIL regram_frame got left=%0d fd=%0d required 0/1",
                      sb_q.size(), fd_count);
    end
    total++;
    if (max_addr !== 32'h0000_118C) begin
      bad++; $display("FAIL regram_max_addr got=%h required=0000118c", max_addr);
    end
    reg_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_continuous();
    test_reset_mid();
    test_restart_regram();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h1000, byte address of board word 0.
REQ-002 Parameter: N_WORDS, default 100, number of 32-bit board words scanned per frame.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  request one full-frame scan; sampled only in IDLE.
REQ-006 Port: continuous  in  1  when 1 at frame end, next frame starts without a new start.
REQ-007 Port: mem_addr  out  32  byte address presented to the board RAM read port.
REQ-008 Port: mem_rd_en  out  1  high while mem_addr is a valid read request.
REQ-009 Port: mem_rdata  in  32  board RAM read data.
REQ-010 Port: out_valid  out  1  out_index/out_data hold a word for the consumer.
REQ-011 Port: out_ready  in  1  consumer accepts the word when out_valid && out_ready.
REQ-012 Port: out_index  out  7  board word index 0..N_WORDS-1.
REQ-013 Port: out_data  out  32  board word value.
REQ-014 Port: busy  out  1  high in any state other than IDLE.
REQ-015 Port: frame_done  out  1  one-cycle pulse on acceptance of word N_WORDS-1.

Function
REQ-016 States: IDLE, ADDR, CAPT, OUT; encoding is free.
REQ-017 IDLE: start=1 -> index cleared to 0, go to ADDR; start=0 -> stay.
REQ-018 ADDR: mem_addr = BASE_ADDR + (index << 2), mem_rd_en=1; next cycle go to CAPT.
REQ-019 CAPT: mem_addr and mem_rd_en are held unchanged; mem_rdata is registered into out_data and index into out_index at the end of this cycle; go to OUT.
REQ-020 Read latency: mem_rdata is sampled exactly one cycle after the address first appears, so both combinational and 1-cycle registered RAM reads are supported.
REQ-021 OUT: out_valid=1, mem_rd_en=0; out_index and out_data stay stable until acceptance.
REQ-022 OUT with out_ready=0: stay in OUT with no change to any output.
REQ-023 OUT, accept, index < N_WORDS-1: index increments by 1 and the FSM goes to ADDR.
REQ-024 OUT, accept, index = N_WORDS-1: frame_done=1 for that cycle and index wraps to 0; the FSM goes to ADDR if continuous=1, else to IDLE.
REQ-025 Throughput: one word per 3 cycles with out_ready held high; 300 cycles per 100-word frame.
REQ-026 Address range: generated addresses stay within BASE_ADDR..BASE_ADDR+4*(N_WORDS-1) (default 0x1000..0x118C), always word-aligned, and never reach BASE_ADDR+4*N_WORDS (0x1190).
REQ-027 start asserted while busy is ignored and does not restart or extend the frame.
REQ-028 continuous is sampled only at the final-word acceptance; changes at other times have no effect.
REQ-029 mem_rd_en is 0 in IDLE and OUT; the block never drives a write.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, index=0, mem_addr=BASE_ADDR, mem_rd_en=0, out_valid=0, out_index=0, out_data=0, busy=0, frame_done=0.
REQ-031 Reset mid-frame (any state) aborts the scan with no frame_done, and the first post-reset frame again begins at index 0.
REQ-032 start is ignored in any cycle in which rst=1.

Structure
REQ-033 Package board_pkg holds BOARD_BASE (32'h1000), BOARD_WORDS (100), BOARD_END (32'h1190), the 7-bit board index typedef, and the scanner state enum.
REQ-034 One sub-module, board_idx_counter (clear, increment, wrap at BOARD_WORDS-1, last flag), is instantiated for the index.
REQ-035 RTL target: 120-400 lines including the sub-module.

Verification
REQ-036 RAM model words i=0..99 set to 32'hA000_0000+i; start pulse, out_ready=1 -> 100 words in order, out_data=32'hA000_0000+out_index, single frame_done on index 99, back in IDLE, 300 cycles from start to IDLE.
REQ-037 Backpressure: out_ready=0 for 5 cycles at index 7 -> out_valid stays 1 with out_index=7 and out_data=32'hA000_0007 unchanged, no new mem_rd_en pulse, index 8 address 0x1020 issued only after acceptance.
REQ-038 continuous=1, out_ready=1 -> after index 99 (address 0x118C) the next address is 0x1000 with no IDLE cycle and busy held 1; two frame_done pulses 300 cycles apart.
REQ-039 rst asserted for 1 cycle while in OUT at index 50 -> next cycle all outputs at reset values; a new start yields first word index 0 at address 0x1000.
REQ-040 start re-pulsed at index 20 and registered RAM (1-cycle latency) model -> frame continues unaffected, data still matches the RAM model, and an address assertion confirms no address >= 0x1190 across the frame.
